// File: rtl/tt_uio_arbiter_if.sv
// tt_uio_arbiter_if: requester handshake and shared uio pad bus bundle.
// The slave view belongs to the arbiter. The master view belongs to the requesters and pad model.
interface tt_uio_arbiter_if;
  logic [1:0] req;
  logic [1:0] we;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [1:0] gnt;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic [1:0] rvalid;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output req, we, wdata0, wdata1, uio_in,
    input  gnt, ack, rdata, rvalid, uio_out, uio_oe
  );

  modport slave (
    input  req, we, wdata0, wdata1, uio_in,
    output gnt, ack, rdata, rvalid, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_uio_arbiter.sv
// tt_uio_arbiter: two-requester round-robin arbiter for the shared uio pad bus.
// Each winner first gets TURN_CYC idle cycles with the pads released.
// It then owns the bus for up to BURST_MAX beats in a single direction.
// The pad enables are a decode of registered state, so an asserted reset
// releases the bus at once, without waiting for a clock edge.
module tt_uio_arbiter #(
  parameter int unsigned BURST_MAX = 4,
  parameter int unsigned TURN_CYC  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  tt_uio_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OWN  = 2'd2
  } state_t;

  localparam logic [3:0] BEAT_LAST = 4'(BURST_MAX - 1);
  localparam logic [1:0] TURN_LAST = 2'(TURN_CYC - 1);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       dir_q, dir_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] turn_cnt_q, turn_cnt_d;
  logic       rr_q, rr_d;
  logic [1:0] gnt_q, gnt_d;
  logic [7:0] rdata_q;
  logic [1:0] rvalid_q;

  logic       arb_valid;
  logic       arb_idx;
  logic       own_req;
  logic       own_we;
  logic [7:0] own_wdata;
  logic       beat_ok;
  logic       read_beat;
  logic       burst_end;
  logic       take_grant;
  logic [1:0] ack_c;
  logic [7:0] uio_out_c;
  logic [7:0] uio_oe_c;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Round-robin pick: the index held in rr goes first, then the other one.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = rr_q;
    if (bus.req[rr_q]) begin
      arb_valid = 1'b1;
      arb_idx   = rr_q;
    end else if (bus.req[~rr_q]) begin
      arb_valid = 1'b1;
      arb_idx   = ~rr_q;
    end
  end

  // Current owner's request view and whether a beat is accepted this cycle.
  // A beat counts only when the owner's direction matches the latched direction.
  always_comb begin
    own_req   = bus.req[owner_q];
    own_we    = bus.we[owner_q];
    own_wdata = owner_q ? bus.wdata1 : bus.wdata0;
    beat_ok   = ena && (state_q == OWN) && own_req && (own_we == dir_q);
    read_beat = beat_ok && !dir_q;
  end

  // Next-state logic and pad/ack decode for the IDLE -> TURN -> OWN sequence.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    dir_d      = dir_q;
    beat_cnt_d = beat_cnt_q;
    turn_cnt_d = turn_cnt_q;
    rr_d       = rr_q;
    gnt_d      = gnt_q;
    ack_c      = '0;
    uio_out_c  = '0;
    uio_oe_c   = '0;
    burst_end  = 1'b0;
    take_grant = 1'b0;

    if (!ena) begin
      state_d = IDLE;
      gnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          take_grant = arb_valid;
        end
        TURN: begin
          if (turn_cnt_q == 2'd0) begin
            state_d = OWN;
          end else begin
            turn_cnt_d = turn_cnt_q - 2'd1;
          end
        end
        OWN: begin
          if (dir_q) begin
            uio_oe_c = 8'hFF;
          end
          if (beat_ok) begin
            ack_c = onehot(owner_q);
            if (dir_q) begin
              uio_out_c = own_wdata;
            end
            if (beat_cnt_q == BEAT_LAST) begin
              burst_end = 1'b1;
            end else begin
              beat_cnt_d = beat_cnt_q + 4'd1;
            end
          end else begin
            burst_end = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      endcase

      if (burst_end) begin
        if (arb_valid) begin
          take_grant = 1'b1;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end

      if (take_grant) begin
        state_d    = TURN;
        owner_d    = arb_idx;
        dir_d      = bus.we[arb_idx];
        rr_d       = ~arb_idx;
        turn_cnt_d = TURN_LAST;
        beat_cnt_d = '0;
        gnt_d      = onehot(arb_idx);
      end
    end
  end

  // State, grant and arbitration bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      dir_q      <= 1'b0;
      beat_cnt_q <= '0;
      turn_cnt_q <= '0;
      rr_q       <= 1'b0;
      gnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      dir_q      <= dir_d;
      beat_cnt_q <= beat_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
    end
  end

  // Read path: capture the pads on a read beat and flag it for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= '0;
      if (read_beat) begin
        rdata_q  <= bus.uio_in;
        rvalid_q <= onehot(owner_q);
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_c;
  assign bus.uio_out = uio_out_c;
  assign bus.uio_oe  = uio_oe_c;
  assign bus.rdata   = rdata_q;
  assign bus.rvalid  = rvalid_q;

endmodule

// File: tb/tb_tt_uio_arbiter.sv
// tb_tt_uio_arbiter: directed scenarios for the uio arbiter.
// Each scenario pushes its expected ack and rvalid events, stamped with the cycle they are due in.
// A free-running monitor pops and compares them whenever the DUT presents one.
module tb_tt_uio_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;

  tt_uio_arbiter_if bus ();

  tt_uio_arbiter #(
    .BURST_MAX (4),
    .TURN_CYC  (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  typedef struct {
    int         cyc;
    logic [1:0] ack;
    logic [7:0] oe;
    logic [7:0] out;
  } beat_t;

  typedef struct {
    int         cyc;
    logic [1:0] rvalid;
    logic [7:0] rdata;
  } rd_t;

  beat_t beat_q[$];
  rd_t   rd_q[$];
  beat_t mon_b;
  rd_t   mon_r;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int c0;
  int c1;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Cycle counter; a cycle index names the period that follows that rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w, input logic [7:0] d0, input logic [7:0] d1);
    bus.req    = r;
    bus.we     = w;
    bus.wdata0 = d0;
    bus.wdata1 = d1;
  endtask

  task automatic expectBeat(input int c, input logic [1:0] a, input logic [7:0] oe, input logic [7:0] out);
    beat_t b;
    b.cyc = c;
    b.ack = a;
    b.oe  = oe;
    b.out = out;
    beat_q.push_back(b);
  endtask

  task automatic expectRead(input int c, input logic [1:0] rv, input logic [7:0] d);
    rd_t r;
    r.cyc    = c;
    r.rvalid = rv;
    r.rdata  = d;
    rd_q.push_back(r);
  endtask

  // Move to 1 time unit after the rising edge that begins cycle k.
  task automatic startOf(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Move to the falling edge inside cycle k.
  task automatic sampleOf(input int k);
    @(negedge clk);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic doReset();
    startOf(cyc + 1);
    rst_n = 1'b0;
    ena   = 1'b1;
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00);
    bus.uio_in = 8'h00;
    sampleOf(cyc + 1);
    checkOutput("reset gnt", 32'(bus.gnt), 32'h0);
    checkOutput("reset ack", 32'(bus.ack), 32'h0);
    checkOutput("reset uio_oe", 32'(bus.uio_oe), 32'h0);
    checkOutput("reset uio_out", 32'(bus.uio_out), 32'h0);
    checkOutput("reset rvalid", 32'(bus.rvalid), 32'h0);
    checkOutput("reset rdata", 32'(bus.rdata), 32'h0);
    startOf(cyc + 1);
    rst_n = 1'b1;
  endtask

  // Monitor: pop and compare one expected event for every ack or rvalid the DUT shows.
  always @(negedge clk) begin
    if (bus.ack !== 2'b00) begin
      if (beat_q.size() == 0) begin
        checkOutput("unexpected ack", 32'(bus.ack), 32'h0);
      end else begin
        mon_b = beat_q.pop_front();
        checkOutput("beat cycle", 32'(cyc), 32'(mon_b.cyc));
        checkOutput("beat ack", 32'(bus.ack), 32'(mon_b.ack));
        checkOutput("beat gnt", 32'(bus.gnt), 32'(mon_b.ack));
        checkOutput("beat uio_oe", 32'(bus.uio_oe), 32'(mon_b.oe));
        checkOutput("beat uio_out", 32'(bus.uio_out), 32'(mon_b.out));
      end
    end
    if (bus.rvalid !== 2'b00) begin
      if (rd_q.size() == 0) begin
        checkOutput("unexpected rvalid", 32'(bus.rvalid), 32'h0);
      end else begin
        mon_r = rd_q.pop_front();
        checkOutput("read cycle", 32'(cyc), 32'(mon_r.cyc));
        checkOutput("read rvalid", 32'(bus.rvalid), 32'(mon_r.rvalid));
        checkOutput("read rdata", 32'(bus.rdata), 32'(mon_r.rdata));
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete, vectors=%0d", vectors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    rst_n = 1'b0;
    ena   = 1'b1;
    applyStimulus(2'b00, 2'b00, 8'h00, 8'h00);
    bus.uio_in = 8'h00;

    // Single writer: two back-to-back 4-beat bursts, then req drops during TURN.
    $display("[TB] scenario: single write");
    doReset();
    applyStimulus(2'b01, 2'b01, 8'hA5, 8'h00);
    c0 = cyc;
    for (int k = 2; k <= 5; k++) expectBeat(c0 + k, 2'b01, 8'hFF, 8'hA5);
    for (int k = 7; k <= 10; k++) expectBeat(c0 + k, 2'b01, 8'hFF, 8'hA5);
    sampleOf(c0 + 1);
    checkOutput("A turn gnt", 32'(bus.gnt), 32'h1);
    checkOutput("A turn uio_oe", 32'(bus.uio_oe), 32'h0);
    sampleOf(c0 + 6);
    checkOutput("A return gnt", 32'(bus.gnt), 32'h1);
    checkOutput("A return uio_oe", 32'(bus.uio_oe), 32'h0);
    startOf(c0 + 11);
    bus.req = 2'b00;
    sampleOf(c0 + 12);
    checkOutput("A empty own gnt", 32'(bus.gnt), 32'h1);
    checkOutput("A empty own ack", 32'(bus.ack), 32'h0);
    checkOutput("A empty own uio_oe", 32'(bus.uio_oe), 32'hFF);
    checkOutput("A empty own uio_out", 32'(bus.uio_out), 32'h0);
    sampleOf(c0 + 13);
    checkOutput("A idle gnt", 32'(bus.gnt), 32'h0);
    checkOutput("A idle uio_oe", 32'(bus.uio_oe), 32'h0);

    // Contention: both write, grants alternate 0, 1, 0, 1.
    $display("[TB] scenario: contention");
    doReset();
    applyStimulus(2'b11, 2'b11, 8'h11, 8'h22);
    c0 = cyc;
    for (int k = 2; k <= 5; k++) expectBeat(c0 + k, 2'b01, 8'hFF, 8'h11);
    for (int k = 7; k <= 10; k++) expectBeat(c0 + k, 2'b10, 8'hFF, 8'h22);
    for (int k = 12; k <= 15; k++) expectBeat(c0 + k, 2'b01, 8'hFF, 8'h11);
    sampleOf(c0 + 1);
    checkOutput("B first gnt", 32'(bus.gnt), 32'h1);
    sampleOf(c0 + 6);
    checkOutput("B second gnt", 32'(bus.gnt), 32'h2);
    checkOutput("B turn uio_oe", 32'(bus.uio_oe), 32'h0);
    sampleOf(c0 + 11);
    checkOutput("B third gnt", 32'(bus.gnt), 32'h1);
    startOf(c0 + 16);
    bus.req = 2'b00;
    sampleOf(c0 + 16);
    checkOutput("B fourth gnt", 32'(bus.gnt), 32'h2);
    sampleOf(c0 + 18);
    checkOutput("B idle gnt", 32'(bus.gnt), 32'h0);

    // Reader 1: the pads change every cycle, so rdata must hold the value seen on the beat's own edge.
    $display("[TB] scenario: read");
    doReset();
    applyStimulus(2'b10, 2'b00, 8'h00, 8'h00);
    bus.uio_in = 8'hC0;
    c0 = cyc;
    for (int k = 2; k <= 5; k++) begin
      expectBeat(c0 + k, 2'b10, 8'h00, 8'h00);
      expectRead(c0 + k + 1, 2'b10, 8'(8'hC0 + k));
    end
    for (int k = 1; k <= 7; k++) begin
      startOf(c0 + k);
      bus.uio_in = 8'(8'hC0 + k);
      if (k == 7) bus.req = 2'b00;
      if (k == 1) begin
        sampleOf(c0 + 1);
        checkOutput("C turn gnt", 32'(bus.gnt), 32'h2);
        checkOutput("C turn uio_oe", 32'(bus.uio_oe), 32'h0);
      end
      if (k == 6) begin
        sampleOf(c0 + 6);
        checkOutput("C return gnt", 32'(bus.gnt), 32'h2);
        checkOutput("C return uio_oe", 32'(bus.uio_oe), 32'h0);
      end
    end
    sampleOf(c0 + 7);
    checkOutput("C empty own uio_oe", 32'(bus.uio_oe), 32'h0);
    sampleOf(c0 + 8);
    checkOutput("C idle gnt", 32'(bus.gnt), 32'h0);

    // Direction flip: two writes, we drops, then a turnaround and four reads.
    $display("[TB] scenario: direction flip");
    doReset();
    applyStimulus(2'b01, 2'b01, 8'h5A, 8'h00);
    bus.uio_in = 8'h77;
    c0 = cyc;
    expectBeat(c0 + 2, 2'b01, 8'hFF, 8'h5A);
    expectBeat(c0 + 3, 2'b01, 8'hFF, 8'h5A);
    for (int k = 6; k <= 9; k++) begin
      expectBeat(c0 + k, 2'b01, 8'h00, 8'h00);
      expectRead(c0 + k + 1, 2'b01, 8'h77);
    end
    startOf(c0 + 4);
    bus.we = 2'b00;
    sampleOf(c0 + 4);
    checkOutput("D flip ack", 32'(bus.ack), 32'h0);
    checkOutput("D flip uio_oe", 32'(bus.uio_oe), 32'hFF);
    checkOutput("D flip uio_out", 32'(bus.uio_out), 32'h0);
    sampleOf(c0 + 5);
    checkOutput("D turn uio_oe", 32'(bus.uio_oe), 32'h0);
    checkOutput("D turn gnt", 32'(bus.gnt), 32'h1);
    startOf(c0 + 10);
    bus.req = 2'b00;
    sampleOf(c0 + 12);
    checkOutput("D idle gnt", 32'(bus.gnt), 32'h0);

    // Reset in the middle of a write burst releases the bus without a clock edge.
    $display("[TB] scenario: reset mid-write");
    doReset();
    applyStimulus(2'b01, 2'b01, 8'hC3, 8'h00);
    c0 = cyc;
    expectBeat(c0 + 2, 2'b01, 8'hFF, 8'hC3);
    startOf(c0 + 3);
    rst_n = 1'b0;
    #1;
    checkOutput("E async uio_oe", 32'(bus.uio_oe), 32'h0);
    checkOutput("E async gnt", 32'(bus.gnt), 32'h0);
    checkOutput("E async ack", 32'(bus.ack), 32'h0);
    startOf(c0 + 4);
    rst_n = 1'b1;
    applyStimulus(2'b11, 2'b11, 8'hC3, 8'h3C);
    c1 = cyc;
    expectBeat(c1 + 2, 2'b01, 8'hFF, 8'hC3);
    sampleOf(c1 + 1);
    checkOutput("E post-reset gnt", 32'(bus.gnt), 32'h1);
    startOf(c1 + 3);
    bus.req = 2'b00;
    sampleOf(c1 + 4);
    checkOutput("E idle gnt", 32'(bus.gnt), 32'h0);

    // Enable drop during OWN: ack and pads cut at once, IDLE next edge, rr kept.
    $display("[TB] scenario: enable low");
    doReset();
    applyStimulus(2'b01, 2'b01, 8'hE7, 8'h00);
    c0 = cyc;
    expectBeat(c0 + 2, 2'b01, 8'hFF, 8'hE7);
    expectBeat(c0 + 3, 2'b01, 8'hFF, 8'hE7);
    expectBeat(c0 + 9, 2'b10, 8'hFF, 8'h9B);
    startOf(c0 + 4);
    ena = 1'b0;
    #1;
    checkOutput("F ena ack", 32'(bus.ack), 32'h0);
    checkOutput("F ena uio_oe", 32'(bus.uio_oe), 32'h0);
    checkOutput("F ena gnt held", 32'(bus.gnt), 32'h1);
    startOf(c0 + 5);
    applyStimulus(2'b11, 2'b11, 8'hE7, 8'h9B);
    sampleOf(c0 + 5);
    checkOutput("F idle gnt", 32'(bus.gnt), 32'h0);
    checkOutput("F idle uio_oe", 32'(bus.uio_oe), 32'h0);
    sampleOf(c0 + 6);
    checkOutput("F disabled gnt", 32'(bus.gnt), 32'h0);
    startOf(c0 + 7);
    ena = 1'b1;
    sampleOf(c0 + 8);
    checkOutput("F rr kept gnt", 32'(bus.gnt), 32'h2);
    startOf(c0 + 10);
    bus.req = 2'b00;
    sampleOf(c0 + 11);
    checkOutput("F idle again gnt", 32'(bus.gnt), 32'h0);

    sampleOf(cyc + 3);
    checkOutput("beat queue drained", 32'(beat_q.size()), 32'h0);
    checkOutput("read queue drained", 32'(rd_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
